cr_xp10_decomp_lz77_pfx_sched: RTL

Prefix-slot scheduler for the XP10 decompressor LZ77 history buffer. Each frame may request a predefined prefix. The block owns the three 64-entry prefix RAM slots, keeps a tag per slot and serves repeat requests without reloading. On a miss it fetches and streams the 64 prefix words into an LRU-chosen slot, then drives the one-hot slot `in_use` flags that steer history-buffer accesses to addresses below 64 until end of frame.

---
 rtl/cr_xp10_decompPKG.sv | 25 ++
 rtl/cr_xp10_decomp_pfx_lru.sv | 35 +++
 rtl/cr_xp10_decomp_lz77_pfx_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cr_xp10_decompPKG.sv
// Shared XP10 decompressor definitions used by the prefix-slot scheduler.
package cr_xp10_decompPKG;

  localparam int PFX_SLOTS = 3;
  localparam int PFX_ID_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FETCH,
    LOAD,
    ACTIVE
  } pfx_sched_state_e;

  typedef struct packed {
    logic                valid;
    logic [PFX_ID_W-1:0] id;
  } pfx_tag_t;

  // One-hot slot select from a slot index.
  function automatic logic [PFX_SLOTS-1:0] slot_onehot(input logic [1:0] s);
    return PFX_SLOTS'(1) << s;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_pfx_lru.sv
// Three-way age tracker for the prefix slots. ord_q[0] is the oldest slot,
// ord_q[2] the most recently used; a touch moves a slot to the young end.
module cr_xp10_decomp_pfx_lru
  import cr_xp10_decompPKG::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       touch_i,
  input  logic [1:0] touch_slot_i,
  output logic [1:0] victim_o
);

  logic [1:0] ord_q [PFX_SLOTS];

  // Age order update: remove the touched slot and append it as youngest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_q[0] <= 2'd0;
      ord_q[1] <= 2'd1;
      ord_q[2] <= 2'd2;
    end else if (touch_i) begin
      if (ord_q[0] == touch_slot_i) begin
        ord_q[0] <= ord_q[1];
        ord_q[1] <= ord_q[2];
        ord_q[2] <= touch_slot_i;
      end else if (ord_q[1] == touch_slot_i) begin
        ord_q[1] <= ord_q[2];
        ord_q[2] <= touch_slot_i;
      end
    end
  end

  assign victim_o = ord_q[0];

endmodule

// File: rtl/cr_xp10_decomp_lz77_pfx_sched.sv
// Prefix-slot scheduler for the LZ77 history buffer. Owns three prefix RAM
// slots, fetches/streams a prefix on a miss and steers low history accesses
// through in_use while a frame is active.
// Build option: CR_XP10_DECOMP_PFX_CACHE_EN enables tag matching, LRU victim
// choice and flush; without it every request reloads slot 0.
module cr_xp10_decomp_lz77_pfx_sched
  import cr_xp10_decompPKG::*;
#(
  parameter int ID_W      = 10,
  parameter int PFX_WORDS = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic                         req_none,
  input  logic [ID_W-1:0]              req_id,
  output logic                         req_ready,
  output logic                         fetch_valid,
  output logic [ID_W-1:0]              fetch_id,
  input  logic                         fetch_ready,
  input  logic                         pd_valid,
  input  logic [127:0]                 pd_data,
  input  logic                         pd_last,
  output logic                         pd_ready,
  output logic [PFX_SLOTS-1:0]         pld_wr,
  output logic [$clog2(PFX_WORDS)-1:0] pld_waddr,
  output logic [127:0]                 pld_wdata,
  output logic [PFX_SLOTS-1:0]         in_use,
  output logic                         pfx_done,
  output logic                         pfx_err,
  input  logic                         frame_eof,
  input  logic                         pfx_flush
);

  localparam int AW = $clog2(PFX_WORDS);
  localparam logic [AW-1:0] LAST_A = AW'(PFX_WORDS - 1);

  pfx_sched_state_e     state_q, state_d;
  logic [ID_W-1:0]      id_q;
  logic                 none_q, fin_q, drain_q, done_q, err_q;
  logic [1:0]           slot_q;
  logic [AW-1:0]        cnt_q, waddr_q;
  logic [PFX_SLOTS-1:0] wr_q;
  logic [127:0]         wdata_q;
  logic                 hit;
  logic [1:0]           hit_slot, vic_slot;
  logic                 beat, at_last, load_ok, load_err;

  assign beat     = (state_q == LOAD) && !fin_q && pd_valid;
  assign at_last  = (cnt_q == LAST_A);
  assign load_ok  = beat && pd_last && at_last;
  assign load_err = beat && (pd_last ^ at_last);

  // Next-state and handshake outputs. A pending drain of a bad load blocks
  // the next fetch so stale beats never land in a new slot.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    fetch_valid = 1'b0;
    pd_ready    = drain_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_none ? ACTIVE : LOOKUP;
      end
      LOOKUP: state_d = hit ? ACTIVE : FETCH;
      FETCH: begin
        fetch_valid = !drain_q;
        if (fetch_ready && !drain_q) state_d = LOAD;
      end
      LOAD: begin
        pd_ready = !fin_q;
        if (fin_q)         state_d = ACTIVE;
        else if (load_err) state_d = IDLE;
      end
      ACTIVE: if (frame_eof) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request capture, word counter and the registered slot write port.
  // fin_q holds LOAD one extra cycle so in_use follows the final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      none_q  <= 1'b0;
      slot_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_ready && req_valid) begin
        id_q   <= req_id;
        none_q <= req_none;
      end
      if (state_q == LOOKUP) slot_q <= hit ? hit_slot : vic_slot;
      if (fetch_valid && fetch_ready) cnt_q <= '0;
      else if (beat)                  cnt_q <= cnt_q + AW'(1);
      fin_q <= load_ok;
      if (load_err && !pd_last)               drain_q <= 1'b1;
      else if (drain_q && pd_valid && pd_last) drain_q <= 1'b0;
      done_q <= ((state_d == ACTIVE) && (state_q != ACTIVE)) || load_err;
      err_q  <= load_err;
      wr_q   <= beat ? slot_onehot(slot_q) : '0;
      if (beat) begin
        waddr_q <= cnt_q;
        wdata_q <= pd_data;
      end
    end
  end

  assign fetch_id  = id_q;
  assign pld_wr    = wr_q;
  assign pld_waddr = waddr_q;
  assign pld_wdata = wdata_q;
  assign in_use    = ((state_q == ACTIVE) && !none_q) ? slot_onehot(slot_q) : '0;
  assign pfx_done  = done_q;
  assign pfx_err   = err_q;

`ifdef CR_XP10_DECOMP_PFX_CACHE_EN
  pfx_tag_t   tag_q [PFX_SLOTS];
  logic       flush_pend_q, flush_clr, touch;
  logic [1:0] lru_vic;

  // Flush in IDLE applies at once (ahead of a same-cycle lookup); otherwise
  // it waits for the return to IDLE, taking any slot this frame loaded.
  assign flush_clr = ((state_q == IDLE) && pfx_flush) ||
                     ((state_q != IDLE) && (state_d == IDLE) && (flush_pend_q || pfx_flush));
  assign touch     = (state_q == ACTIVE) && frame_eof && !none_q;

  // Tag match and victim pick; the descending scan lets the lowest index win.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    vic_slot = lru_vic;
    for (int i = PFX_SLOTS - 1; i >= 0; i--) begin
      if (tag_q[i].valid && (tag_q[i].id == PFX_ID_W'(id_q))) begin
        hit      = 1'b1;
        hit_slot = 2'(i);
      end
      if (!tag_q[i].valid) vic_slot = 2'(i);
    end
  end

  // Tag store: victim invalidated on miss, validated only after a clean load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PFX_SLOTS; i++) tag_q[i] <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if ((state_q == LOOKUP) && !hit) begin
        tag_q[vic_slot].valid <= 1'b0;
        tag_q[vic_slot].id    <= PFX_ID_W'(id_q);
      end
      if (fin_q) tag_q[slot_q].valid <= 1'b1;
      if (flush_clr)
        for (int i = 0; i < PFX_SLOTS; i++) tag_q[i].valid <= 1'b0;
      flush_pend_q <= flush_clr ? 1'b0 : (flush_pend_q || pfx_flush);
    end
  end

  cr_xp10_decomp_pfx_lru u_lru (
    .clk          (clk),
    .rst_n        (rst_n),
    .touch_i      (touch),
    .touch_slot_i (slot_q),
    .victim_o     (lru_vic)
  );
`else
  logic unused_flush;
  assign unused_flush = pfx_flush;
  assign hit          = 1'b0;
  assign hit_slot     = '0;
  assign vic_slot     = '0;
`endif

endmodule
